// File: rtl/imm_gen_pkg.sv
// Shared definitions for the RV64I immediate generator: base opcodes,
// the immediate format encoding and the shift funct3 codes.
package imm_gen_pkg;

  // Base opcodes (instr[6:0]) that carry an immediate, plus the two
  // register-register groups that are legal but immediate-free.
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;

  // funct3 values that turn an OP-IMM / OP-IMM-32 into a shift
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  // Immediate format code as presented on the fmt outputs
  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } imm_fmt_t;

  // True when funct3 selects one of the immediate shift instructions
  function automatic logic is_shift_f3(input logic [2:0] funct3);
    return (funct3 == F3_SLL) || (funct3 == F3_SRL_SRA);
  endfunction

endpackage

// File: rtl/imm_gen_decode.sv
// Purely combinational immediate extraction: instruction word in,
// sign/zero-extended immediate, format code and illegal flag out.
module imm_gen_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_sh6;
  logic [XLEN-1:0] imm_sh5;
  imm_fmt_t        fmt_e;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  // Every candidate immediate is formed in parallel; the case below only
  // selects. Signed formats replicate instr[31]; shift amounts are
  // zero-extended so funct6/funct7 bits never reach the result.
  assign imm_i   = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s   = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b   = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
  assign imm_u   = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
  assign imm_j   = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12],
                    instr[20], instr[30:21], 1'b0};
  assign imm_sh6 = {{(XLEN-6){1'b0}}, instr[25:20]};
  assign imm_sh5 = {{(XLEN-5){1'b0}}, instr[24:20]};

  // Opcode decode selects the format and matching immediate
  always_comb begin
    imm     = '0;
    fmt_e   = FMT_NONE;
    illegal = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
        fmt_e = FMT_I;
        imm   = imm_i;
      end
      OPC_OPIMM: begin
        if (is_shift_f3(funct3)) begin
          fmt_e = FMT_SHAMT;
          imm   = imm_sh6;
        end else begin
          fmt_e = FMT_I;
          imm   = imm_i;
        end
      end
      OPC_OPIMM32: begin
        if (is_shift_f3(funct3)) begin
          fmt_e = FMT_SHAMT;
          imm   = imm_sh5;
        end else begin
          fmt_e = FMT_I;
          imm   = imm_i;
        end
      end
      OPC_STORE: begin
        fmt_e = FMT_S;
        imm   = imm_s;
      end
      OPC_BRANCH: begin
        fmt_e = FMT_B;
        imm   = imm_b;
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt_e = FMT_U;
        imm   = imm_u;
      end
      OPC_JAL: begin
        fmt_e = FMT_J;
        imm   = imm_j;
      end
      OPC_OP, OPC_OP32: begin
        fmt_e = FMT_NONE;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  assign fmt = fmt_e;

endmodule

// File: rtl/imm_gen.sv
// RV64I immediate generator: combinational decode result for operand
// muxing plus a registered copy with a valid flag for later stages.
module imm_gen
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instr,
  input  logic            en,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal,
  output logic [XLEN-1:0] imm_q,
  output logic [2:0]      fmt_q,
  output logic            valid_q
);

  if (XLEN != 64) begin : g_xlen_check
    $error("imm_gen: only XLEN=64 is supported");
  end

  imm_gen_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .instr  (instr),
    .imm    (imm),
    .fmt    (fmt),
    .illegal(illegal)
  );

  // Capture stage: load on en, otherwise hold data and drop valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_q   <= '0;
      fmt_q   <= FMT_NONE;
      valid_q <= 1'b0;
    end else if (en) begin
      imm_q   <= imm;
      fmt_q   <= fmt;
      valid_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_gen.sv
// Self-checking bench for imm_gen: directed cases from the decode rules,
// then randomized instructions against an arithmetic reference model.
module tb_imm_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        en = 1'b0;
  logic [63:0] imm;
  logic [2:0]  fmt;
  logic        illegal;
  logic [63:0] imm_q;
  logic [2:0]  fmt_q;
  logic        valid_q;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] m_imm_q = '0;
  logic [2:0]  m_fmt_q = '0;
  logic        m_valid_q = 1'b0;

  imm_gen #(
    .XLEN(64)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .instr  (instr),
    .en     (en),
    .imm    (imm),
    .fmt    (fmt),
    .illegal(illegal),
    .imm_q  (imm_q),
    .fmt_q  (fmt_q),
    .valid_q(valid_q)
  );

  always #5 clk = ~clk;

  // Interpret an unsigned field value as a two's complement number
  function automatic longint as_signed(input longint raw, input int width);
    if (raw >= (longint'(1) << (width - 1)))
      return raw - (longint'(1) << width);
    return raw;
  endfunction

  // Reference: immediate value computed as an integer from field weights
  function automatic void ref_model(input logic [31:0] ins,
                                    output logic [63:0] e_imm,
                                    output logic [2:0] e_fmt,
                                    output logic e_ill);
    longint v;
    int f3;
    v = 0;
    e_fmt = 3'd0;
    e_ill = 1'b0;
    f3 = int'(ins[14:12]);
    case (ins[6:0])
      7'h03, 7'h67, 7'h73: begin
        e_fmt = 3'd1;
        v = as_signed(longint'(ins[31:20]), 12);
      end
      7'h13, 7'h1B: begin
        if (f3 == 1 || f3 == 5) begin
          e_fmt = 3'd6;
          v = (ins[6:0] == 7'h13) ? longint'(ins[25:20]) : longint'(ins[24:20]);
        end else begin
          e_fmt = 3'd1;
          v = as_signed(longint'(ins[31:20]), 12);
        end
      end
      7'h23: begin
        e_fmt = 3'd2;
        v = as_signed(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12);
      end
      7'h63: begin
        e_fmt = 3'd3;
        v = as_signed(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
                      longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
      end
      7'h37, 7'h17: begin
        e_fmt = 3'd4;
        v = as_signed(longint'(ins[31:12]) * 4096, 32);
      end
      7'h6F: begin
        e_fmt = 3'd5;
        v = as_signed(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 +
                      longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
      end
      7'h33, 7'h3B: e_fmt = 3'd0;
      default: e_ill = 1'b1;
    endcase
    e_imm = 64'(v);
  endfunction

  // Single comparison point; counts every vector and every miscompare
  task automatic check_output(input string tag, input logic [63:0] got,
                              input logic [63:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one instruction, check the combinational outputs against the
  // model, clock it, then check the registered outputs
  task automatic apply_stimulus(input logic [31:0] ins, input logic enable);
    logic [63:0] e_imm;
    logic [2:0]  e_fmt;
    logic        e_ill;
    @(negedge clk);
    instr = ins;
    en = enable;
    #1;
    ref_model(ins, e_imm, e_fmt, e_ill);
    check_output("imm", imm, e_imm);
    check_output("fmt", 64'(fmt), 64'(e_fmt));
    check_output("illegal", 64'(illegal), 64'(e_ill));
    @(posedge clk);
    if (enable) begin
      m_imm_q = e_imm;
      m_fmt_q = e_fmt;
      m_valid_q = 1'b1;
    end else begin
      m_valid_q = 1'b0;
    end
    #1;
    check_output("imm_q", imm_q, m_imm_q);
    check_output("fmt_q", 64'(fmt_q), 64'(m_fmt_q));
    check_output("valid_q", 64'(valid_q), 64'(m_valid_q));
  endtask

  // Directed check of the combinational result against known constants
  task automatic check_directed(input string tag, input logic [31:0] ins,
                                input logic [63:0] exp_imm, input logic [2:0] exp_fmt);
    instr = ins;
    #1;
    check_output({tag, "_imm"}, imm, exp_imm);
    check_output({tag, "_fmt"}, 64'(fmt), 64'(exp_fmt));
  endtask

  logic [6:0] opcodes [12] = '{7'h03, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h37,
                               7'h17, 7'h6F, 7'h67, 7'h73, 7'h33, 7'h3B};

  initial begin
    logic [31:0] r;
    $display("[TB] imm_gen bench start");

    // Reset asserted: registered outputs cleared
    #2 rst_n = 1'b0;
    #2;
    check_output("rst_imm_q", imm_q, 64'h0);
    check_output("rst_fmt_q", 64'(fmt_q), 64'h0);
    check_output("rst_valid_q", 64'(valid_q), 64'h0);

    // Directed decode cases (combinational only, reset still held)
    check_directed("addi", 32'hFFC00093, 64'hFFFFFFFFFFFFFFFC, 3'd1);
    check_directed("andi", 32'h0071F113, 64'h7, 3'd1);
    check_directed("sd", 32'h00303423, 64'h8, 3'd2);
    check_directed("beq", 32'h00208863, 64'h10, 3'd3);
    check_directed("slli", 32'h00329213, 64'h3, 3'd6);
    check_directed("srai", 32'h43F15093, 64'h3F, 3'd6);
    check_directed("sraiw", 32'h43F1509B, 64'h1F, 3'd6);
    check_directed("lui", 32'h123450B7, 64'h12345000, 3'd4);
    check_directed("lui_neg", 32'h800000B7, 64'hFFFFFFFF80000000, 3'd4);
    check_directed("jal", 32'hFFDFF06F, 64'hFFFFFFFFFFFFFFFC, 3'd5);
    check_directed("add", 32'h002081B3, 64'h0, 3'd0);
    check_directed("opc7f", 32'hFFFFFFFF, 64'h0, 3'd0);
    check_output("opc7f_illegal", 64'(illegal), 64'h1);
    check_output("held_valid_q", 64'(valid_q), 64'h0);

    // Release reset between edges, then capture addi -4 on one edge
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(32'hFFC00093, 1'b1);
    check_output("cap_imm_q", imm_q, 64'hFFFFFFFFFFFFFFFC);
    check_output("cap_valid_q", 64'(valid_q), 64'h1);

    // en low: data holds, valid drops
    apply_stimulus(32'h00303423, 1'b0);
    check_output("hold_imm_q", imm_q, 64'hFFFFFFFFFFFFFFFC);
    check_output("hold_valid_q", 64'(valid_q), 64'h0);

    // Reset mid-hold away from any edge: registers clear at once
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("midrst_imm_q", imm_q, 64'h0);
    check_output("midrst_fmt_q", 64'(fmt_q), 64'h0);
    check_output("midrst_imm", imm, 64'h8);
    m_imm_q = '0;
    m_fmt_q = '0;
    m_valid_q = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized instructions, mostly with legal opcodes, random enable
    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      if ($urandom_range(0, 9) < 8) r[6:0] = opcodes[$urandom_range(0, 11)];
      apply_stimulus(r, ($urandom_range(0, 2) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imm_gen.md
Name: imm_gen

Overview:
- RV64I immediate generator in the decode stage.
- Extracts and sign-extends the immediate of an instruction word according to its format: I, S, B, U, J and shift-amount.
- Provides a zero-latency combinational result for decode/ALU-operand muxing.
- Provides a registered copy, with a valid flag, for pipelined consumers.

Parameters:
- XLEN, 64: width of the immediate outputs. Only 64 is supported; elaboration error otherwise.

Ports:
- clk  input  1  system clock; all registered outputs update on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instr  input  32  instruction word.
- en  input  1  capture strobe for the registered outputs.
- imm  output  XLEN  combinational immediate.
- fmt  output  3  combinational format code: 0=R/none, 1=I, 2=S, 3=B, 4=U, 5=J, 6=SHAMT.
- illegal  output  1  combinational flag: opcode not recognised.
- imm_q  output  XLEN  registered imm.
- fmt_q  output  3  registered fmt.
- valid_q  output  1  registered: a capture occurred on the previous enabled edge.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Combinational path: imm, fmt and illegal depend only on instr, with zero latency and no clock involvement.
- Opcode decode uses instr[6:0]:
  - 0000011 LOAD, 1100111 JALR, 1110011 SYSTEM: I. imm = sext(instr[31:20]).
  - 0010011 OP-IMM: funct3 001 or 101 gives SHAMT, imm = zext(instr[25:20]). Any other funct3 gives I, sext(instr[31:20]).
  - 0011011 OP-IMM-32: funct3 001 or 101 gives SHAMT, imm = zext(instr[24:20]). Otherwise I.
  - 0100011 STORE: S. imm = sext({instr[31:25], instr[11:7]}).
  - 1100011 BRANCH: B. imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 0110111 LUI, 0010111 AUIPC: U. imm = sext({instr[31:12], 12'b0}).
  - 1101111 JAL: J. imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 0110011, 0111011 (R-type): fmt=0, imm=0, illegal=0.
  - Any other opcode: fmt=0, imm=0, illegal=1.
- Funct7/funct6 bits of shift instructions never leak into imm; e.g. srai shamt 63 gives 0x3F.
- Sign extension replicates instr[31] for all signed formats.
- Registered path:
  - On each rising clk edge with en=1: imm_q<=imm, fmt_q<=fmt, valid_q<=1.
  - With en=0: imm_q and fmt_q hold; valid_q<=0.
- Reset: while rst_n=0, imm_q=0, fmt_q=0 and valid_q=0, asynchronously.
- Reset is released synchronously to clk, so the first capture occurs on the first enabled edge after release.
- Reset mid-operation clears the registered outputs immediately; the combinational outputs are unaffected.
- The illegal flag is not registered.

Decomposition:
- Shared package imm_gen_pkg holds:
  - opcode localparams (OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_SYSTEM, OPC_OP, OPC_OP32);
  - the fmt enum type imm_fmt_t;
  - funct3 constants for the shifts.
- One natural sub-module, imm_gen_decode: purely combinational, instr to {imm, fmt, illegal}.
- The top adds the output register stage.

Test Plan:
- I-type:
  - addi x1,x0,-4 (0xFFC00093) gives imm=FFFFFFFFFFFFFFFC, fmt=1.
  - andi x2,x3,7 (0x0071F113) gives imm=0x7.
- S-type: sd x3,8(x0) (0x00303423) gives imm=0x8, fmt=2.
- B-type: beq x1,x2,16 (0x00208863) gives imm=0x10, fmt=3.
- Shift:
  - slli x4,x5,3 (0x00329213) gives imm=0x3, fmt=6.
  - srai x1,x2,63 (0x43F15093) gives imm=0x3F.
- U-type and J-type:
  - lui x1,0x12345 (0x123450B7) gives imm=0x12345000.
  - 0x800000B7 gives FFFFFFFF80000000.
  - jal x0,-4 (0xFFDFF06F) gives FFFFFFFFFFFFFFFC, fmt=5.
- Registered path and illegal opcode:
  - rst_n low gives imm_q=0, valid_q=0.
  - Release reset, then en=1 with addi -4 on one edge: imm_q=FFFFFFFFFFFFFFFC, valid_q=1.
  - en=0 on the next edge: imm_q holds, valid_q=0.
  - Opcode 0x7F gives imm=0, illegal=1.
  - Assert rst_n low mid-hold: imm_q clears immediately.
